// File: rtl/alu_operand_sequencer.sv
// Byte-stream front end for the 8-bit ALU: gathers {cmd, A, B}, strobes the ALU, returns two result bytes.
// Optional inter-byte timeout is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_operand_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_flag_sel,
  output logic        alu_go,
  input  logic [13:0] alu_result,
  input  logic        alu_flag,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_SEND_LO, S_SEND_HI
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [1:0]  alu_fs_q, alu_fs_d;
  logic [13:0] res_q, res_d;
  logic        flag_q, flag_d;
  logic        in_xfer, out_xfer, timeout;

  // High byte packs the flag, an overflow hint and the upper result bits.
  function automatic logic [7:0] hi_byte(input logic flag, input logic [13:0] r);
    return {flag, |r[13:8], r[13:8]};
  endfunction

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       bak_a_q, bak_a_d;
  logic [2:0]       bak_op_q, bak_op_d;
  logic [1:0]       bak_fs_q, bak_fs_d;
  logic             waiting;

  // Backups hold the pre-frame operands so an aborted frame leaves the ALU lines untouched.
  always_comb begin
    waiting  = (state_q == S_GET_A) || (state_q == S_GET_B);
    cnt_d    = (waiting && !in_xfer) ? cnt_q + 1'b1 : '0;
    timeout  = waiting && !in_xfer && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    bak_a_d  = bak_a_q;
    bak_op_d = bak_op_q;
    bak_fs_d = bak_fs_q;
    if (state_q == S_IDLE && in_xfer) begin
      bak_a_d  = alu_a_q;
      bak_op_d = alu_op_q;
      bak_fs_d = alu_fs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bak_a_q  <= 8'h00;
      bak_op_q <= 3'd0;
      bak_fs_q <= 2'd0;
    end else begin
      cnt_q    <= cnt_d;
      bak_a_q  <= bak_a_d;
      bak_op_q <= bak_op_d;
      bak_fs_q <= bak_fs_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
    out_valid = (state_q == S_SEND_LO) || (state_q == S_SEND_HI);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    alu_fs_d = alu_fs_q;
    res_d    = res_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          alu_op_d = in_data[2:0];
          alu_fs_d = in_data[4:3];
          state_d  = S_GET_A;
        end
      end
      S_GET_A: begin
        if (in_xfer) begin
          alu_a_d = in_data;
          state_d = S_GET_B;
        end else if (timeout) begin
          state_d = S_IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
          alu_a_d  = bak_a_q;
          alu_op_d = bak_op_q;
          alu_fs_d = bak_fs_q;
`endif
        end
      end
      S_GET_B: begin
        if (in_xfer) begin
          alu_b_d = in_data;
          state_d = S_EXEC;
        end else if (timeout) begin
          state_d = S_IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
          alu_a_d  = bak_a_q;
          alu_op_d = bak_op_q;
          alu_fs_d = bak_fs_q;
`endif
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        flag_d  = alu_flag;
        state_d = S_SEND_LO;
      end
      S_SEND_LO: if (out_xfer) state_d = S_SEND_HI;
      S_SEND_HI: if (out_xfer) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_op_q <= 3'd0;
      alu_fs_q <= 2'd0;
      res_q    <= 14'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      alu_fs_q <= alu_fs_d;
      res_q    <= res_d;
      flag_q   <= flag_d;
    end
  end

  // Output byte is a pure function of the registered state and result, so it stays put under stall.
  always_comb begin
    case (state_q)
      S_SEND_LO: out_data = res_q[7:0];
      S_SEND_HI: out_data = hi_byte(flag_q, res_q);
      default:   out_data = 8'h00;
    endcase
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_flag_sel = alu_fs_q;
  assign alu_go       = (state_q == S_EXEC);
  assign busy         = (state_q != S_IDLE);

endmodule
